// File: rtl/fht_input_loader_pkg.sv
// Shared definitions for the FHT input loader.
// Loader state encodings and frame-size helper.
package fht_input_loader_pkg;

  typedef enum logic [1:0] {
    LD_LOAD   = 2'd0,
    LD_ARM    = 2'd1,
    LD_RUN_LO = 2'd2,
    LD_RUN_HI = 2'd3
  } ld_state_e;

  function automatic int frame_size(input int a_bit);
    return 4 * (1 << a_bit);
  endfunction

endpackage

// File: rtl/fht_bit_rev.sv
// Combinational bit reversal of a W-bit index.
// Bit i of the output is bit W-1-i of the input.
module fht_bit_rev #(
  parameter int W = 10
) (
  input  logic [W-1:0] iIDX,
  output logic [W-1:0] oREV
);

  // mirror the index bits
  always_comb begin
    oREV = '0;
    for (int i = 0; i < W; i++) begin
      oREV[i] = iIDX[W-1-i];
    end
  end

endmodule

// File: rtl/fht_input_loader.sv
// FHT front end: scatters a natural-order frame into four
// banks in bit-reversed order, then starts and tracks the core.
module fht_input_loader
  import fht_input_loader_pkg::*;
#(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iVALID,
  input  logic [D_BIT-1:0] iDATA,
  output logic             oREADY,
  input  logic             iFLUSH,
  input  logic             iFHT_RDY,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic [3:0]       oWE,
  output logic             oSTART,
  output logic             oBUSY,
  output logic             oFRAME_DONE
);

  localparam int IW = A_BIT + 2;
  localparam logic [IW-1:0] LAST = IW'(frame_size(A_BIT) - 1);

  ld_state_e        state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rev;
  logic [3:0]       we_q, we_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic [D_BIT-1:0] data_q, data_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  fht_bit_rev #(
    .W (IW)
  ) u_bit_rev (
    .iIDX (idx_q),
    .oREV (rev)
  );

  assign oREADY      = (state_q == LD_LOAD);
  assign accept      = iVALID & oREADY;
  assign oWE         = we_q;
  assign oADDR_WR    = addr_q;
  assign oDATA_WR    = data_q;
  assign oSTART      = start_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = done_q;

  // next-state and registered-output logic of the loader FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = 4'b0000;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      LD_LOAD: begin
        if (iFLUSH) begin
          idx_d = '0;
        end else if (accept) begin
          we_d   = 4'b0001 << rev[1:0];
          addr_d = rev[IW-1:2];
          data_d = iDATA;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d = LD_ARM;
          end
        end
      end
      LD_ARM: begin
        if (iFLUSH) begin
          idx_d   = '0;
          state_d = LD_LOAD;
        end else if (iFHT_RDY) begin
          start_d = 1'b1;
          state_d = LD_RUN_LO;
        end
      end
      LD_RUN_LO: begin
        if (!iFHT_RDY) begin
          state_d = LD_RUN_HI;
        end
      end
      LD_RUN_HI: begin
        if (iFHT_RDY) begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = LD_LOAD;
        end
      end
    endcase
    busy_d = (state_d != LD_LOAD);
  end

  // state and output registers
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= LD_LOAD;
      idx_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fht_input_loader.sv
// Self-checking bench for fht_input_loader (A_BIT=2, N=16).
// Hand-computed bit-reversed write table plus directed sequences.
module tb_fht_input_loader;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b0;
  logic        iVALID = 1'b0;
  logic [15:0] iDATA = '0;
  logic        oREADY;
  logic        iFLUSH = 1'b0;
  logic        iFHT_RDY = 1'b0;
  logic [1:0]  oADDR_WR;
  logic [15:0] oDATA_WR;
  logic [3:0]  oWE;
  logic        oSTART;
  logic        oBUSY;
  logic        oFRAME_DONE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] we;
    logic [1:0] addr;
  } vec_t;

  vec_t tbl [16];

  fht_input_loader #(
    .A_BIT (2),
    .D_BIT (16)
  ) dut (
    .iCLK        (iCLK),
    .iRESET      (iRESET),
    .iVALID      (iVALID),
    .iDATA       (iDATA),
    .oREADY      (oREADY),
    .iFLUSH      (iFLUSH),
    .iFHT_RDY    (iFHT_RDY),
    .oADDR_WR    (oADDR_WR),
    .oDATA_WR    (oDATA_WR),
    .oWE         (oWE),
    .oSTART      (oSTART),
    .oBUSY       (oBUSY),
    .oFRAME_DONE (oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(oREADY), 1);
    chk({nm, "_we"}, 32'(oWE), 0);
    chk({nm, "_addr"}, 32'(oADDR_WR), 0);
    chk({nm, "_data"}, 32'(oDATA_WR), 0);
    chk({nm, "_start"}, 32'(oSTART), 0);
    chk({nm, "_busy"}, 32'(oBUSY), 0);
    chk({nm, "_done"}, 32'(oFRAME_DONE), 0);
  endtask

  task automatic load_frame(input int base, input bit rnd,
                            input int cnt);
    int n;
    int cyc;
    bit v;
    n = 0;
    cyc = 0;
    while (n < cnt && cyc < 400) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("ready_load", 32'(oREADY), 1);
      iVALID = v;
      iDATA = 16'(base + n);
      tick();
      cyc++;
      if (v) begin
        chk("wr_we", 32'(oWE), 32'(tbl[n].we));
        chk("wr_addr", 32'(oADDR_WR), 32'(tbl[n].addr));
        chk("wr_data", 32'(oDATA_WR), 32'(base + n));
        n++;
      end else begin
        chk("we_idle", 32'(oWE), 0);
      end
    end
    if (n < cnt) chk("load_timeout", 32'(n), 32'(cnt));
    iVALID = 1'b0;
  endtask

  task automatic finish_transform(input int low_cycles);
    int k;
    int pulses;
    pulses = 0;
    iFHT_RDY = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      tick();
      if (oFRAME_DONE) pulses++;
    end
    chk("busy_run", 32'(oBUSY), 1);
    iFHT_RDY = 1'b1;
    k = 0;
    while (!oFRAME_DONE && k < 20) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(oFRAME_DONE), 1);
    chk("done_early", 32'(pulses), 0);
    chk("done_busy", 32'(oBUSY), 0);
    chk("done_ready", 32'(oREADY), 1);
    tick();
    chk("done_pulse", 32'(oFRAME_DONE), 0);
  endtask

  initial begin
    tbl = '{
      '{4'b0001, 2'd0}, '{4'b0001, 2'd2},
      '{4'b0001, 2'd1}, '{4'b0001, 2'd3},
      '{4'b0100, 2'd0}, '{4'b0100, 2'd2},
      '{4'b0100, 2'd1}, '{4'b0100, 2'd3},
      '{4'b0010, 2'd0}, '{4'b0010, 2'd2},
      '{4'b0010, 2'd1}, '{4'b0010, 2'd3},
      '{4'b1000, 2'd0}, '{4'b1000, 2'd2},
      '{4'b1000, 2'd1}, '{4'b1000, 2'd3}
    };

    repeat (3) @(posedge iCLK);
    #1;
    chk_reset_vals("rst");
    @(negedge iCLK);
    iRESET = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    // full frame, core idle, valid held high afterwards
    iFHT_RDY = 1'b1;
    load_frame(0, 1'b0, 16);
    iVALID = 1'b1;
    chk("arm_ready", 32'(oREADY), 0);
    chk("arm_start", 32'(oSTART), 0);
    chk("arm_busy", 32'(oBUSY), 1);
    tick();
    chk("start1", 32'(oSTART), 1);
    chk("start1_we", 32'(oWE), 0);
    tick();
    chk("start1_pulse", 32'(oSTART), 0);
    chk("run_ready", 32'(oREADY), 0);
    chk("run_we", 32'(oWE), 0);
    iVALID = 1'b0;
    finish_transform(40);

    // core busy when frame completes
    iFHT_RDY = 1'b0;
    load_frame(100, 1'b0, 16);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_start", 32'(oSTART), 0);
      chk("hold_busy", 32'(oBUSY), 1);
    end
    iFHT_RDY = 1'b1;
    tick();
    chk("start2", 32'(oSTART), 1);
    tick();
    finish_transform(2);

    // random valid duty
    load_frame(200, 1'b1, 16);
    tick();
    chk("start3", 32'(oSTART), 1);
    tick();
    finish_transform(3);

    // flush concurrent with 8th sample
    load_frame(300, 1'b0, 7);
    iVALID = 1'b1;
    iDATA = 16'hBEEF;
    iFLUSH = 1'b1;
    tick();
    chk("flush_we", 32'(oWE), 0);
    chk("flush_start", 32'(oSTART), 0);
    chk("flush_ready", 32'(oREADY), 1);
    chk("flush_busy", 32'(oBUSY), 0);
    iFLUSH = 1'b0;
    iVALID = 1'b0;
    tick();
    chk("flush_idle_we", 32'(oWE), 0);
    load_frame(400, 1'b0, 16);
    tick();
    chk("start4", 32'(oSTART), 1);
    tick();
    finish_transform(2);

    // flush while armed
    iFHT_RDY = 1'b0;
    load_frame(500, 1'b0, 16);
    iFLUSH = 1'b1;
    tick();
    iFLUSH = 1'b0;
    chk("aflush_ready", 32'(oREADY), 1);
    chk("aflush_busy", 32'(oBUSY), 0);
    iFHT_RDY = 1'b1;
    tick();
    chk("aflush_start", 32'(oSTART), 0);
    chk("aflush_done", 32'(oFRAME_DONE), 0);

    // asynchronous reset during RUN_WAIT_HIGH
    load_frame(600, 1'b0, 16);
    tick();
    chk("start5", 32'(oSTART), 1);
    iFHT_RDY = 1'b0;
    tick();
    tick();
    chk("rh_busy", 32'(oBUSY), 1);
    #3;
    iRESET = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge iCLK);
    iRESET = 1'b1;
    iFHT_RDY = 1'b1;
    tick();
    chk_reset_vals("arst_rel");
    load_frame(700, 1'b0, 16);
    tick();
    chk("start6", 32'(oSTART), 1);
    tick();
    finish_transform(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fht_input_loader.md
Name: fht_input_loader

Overview:
- Front-end stage feeding the FHT core.
- Accepts a stream of N = 4*2^A_BIT real samples over a valid/ready handshake.
- Writes each sample into one of the four data banks at its bit-reversed position, so the zero stage reads natural order from the banks.
- After the last sample is written, pulses the start input of fht_control, tracks its ready line through the transform, and re-opens for the next frame only when the transform has finished.

Parameters:
- A_BIT, 8, address width of one bank; bank depth 2^A_BIT; frame length N = 4*2^A_BIT.
- D_BIT, 16, sample width.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-low reset.
- iVALID  in  1  sample present on iDATA.
- iDATA  in  D_BIT  input sample, natural order.
- oREADY  out  1  loader accepts a sample this cycle.
- iFLUSH  in  1  synchronous frame abort.
- iFHT_RDY  in  1  oRDY of fht_control.
- oADDR_WR  out  A_BIT  bank write address, shared by all banks.
- oDATA_WR  out  D_BIT  bank write data.
- oWE  out  4  one-hot per-bank write enable; bit k drives bank k.
- oSTART  out  1  one-cycle start pulse to fht_control.
- oBUSY  out  1  frame loaded, transform pending or running.
- oFRAME_DONE  out  1  one-cycle pulse when the transform has completed.

Behaviour:
- Reset values: state LOAD, index counter 0, oWE=0, oADDR_WR=0, oDATA_WR=0, oSTART=0, oBUSY=0, oFRAME_DONE=0. oREADY=1 since the state is LOAD.
- Index counter idx has A_BIT+2 bits and counts accepted samples 0..N-1.
- rev = bit-reverse of idx over A_BIT+2 bits.
- Bank select = rev[1:0]; bank address = rev[A_BIT+1:2].
- Accept = iVALID & oREADY.
- Write latency is one cycle. The cycle after an accept:
  - oWE has only bit rev[1:0] set.
  - oADDR_WR = rev[A_BIT+1:2].
  - oDATA_WR = the accepted iDATA.
- oWE is 0 in any cycle not following an accept. oADDR_WR and oDATA_WR hold their last values.
- oREADY is combinational: 1 only in LOAD. iVALID is ignored when oREADY=0.
- State LOAD:
  - Each accept increments idx.
  - An accept at idx=N-1 wraps idx to 0 and moves to ARM; the last write still completes the following cycle.
- State ARM (waits for the core to be idle):
  - If iFHT_RDY=1, assert oSTART for exactly one cycle and go to RUN_WAIT_LOW.
  - Otherwise stay in ARM; no start is issued while the core is busy.
- State RUN_WAIT_LOW: wait for iFHT_RDY=0.
  - fht_control drops ready the cycle after start, registered; tolerate any delay of at least one cycle.
  - Then go to RUN_WAIT_HIGH.
- State RUN_WAIT_HIGH: on iFHT_RDY=1, pulse oFRAME_DONE for one cycle and return to LOAD with idx=0.
- oBUSY = 1 in ARM, RUN_WAIT_LOW and RUN_WAIT_HIGH.
- iFLUSH in LOAD or ARM:
  - idx is set to 0, state goes to LOAD, pending oWE is cleared the next cycle.
  - No oSTART and no oFRAME_DONE.
  - Flush has priority over a simultaneous accept; that sample is dropped.
- iFLUSH in RUN_WAIT_LOW or RUN_WAIT_HIGH is ignored, because the transform cannot be aborted.
- An accept on the same cycle as the idx wrap needs no special handling: the state moves to ARM and oREADY drops the next cycle.
- Asynchronous reset mid-frame discards the partial frame with no start pulse; bank contents are undefined.

Decomposition:
- Add to fht_defines.v:
  - FRAME_SIZE (4*BANK_SIZE).
  - Loader state encodings LD_LOAD, LD_ARM, LD_RUN_LO, LD_RUN_HI (2-bit).
- Sub-module fht_bit_rev: purely combinational, parameter W = A_BIT+2, input iIDX, output oREV.
  - fht_control's coefficient bit-reverse function can migrate to the same module later.

Test Plan (A_BIT=2, N=16, D_BIT=16):
- Stream 16 samples with iDATA=idx, iVALID held high and iFHT_RDY=1 → write sequence (oWE, addr, data) begins:
  - 0001,0,0
  - 0001,2,1
  - 0001,1,2
  - 0001,3,3
  - 0100,0,4 (idx 4 → rev 0010 → bank 2)
  - Continue through idx 15 → 1000,3,15.
  - oSTART pulses one cycle after the last oWE; oREADY stays 0 afterwards.
- Drive iFHT_RDY low 2 cycles after oSTART and high 40 cycles later → exactly one oFRAME_DONE pulse at the rise; oBUSY falls and oREADY=1 the same cycle as oFRAME_DONE.
- Hold iFHT_RDY=0 when the 16th sample is accepted → state stays ARM, no oSTART; raise iFHT_RDY → oSTART pulses on the next cycle.
- Toggle iVALID randomly (about 50% duty) → exactly 16 writes with the same address/bank mapping as the first scenario; no write in cycles not following an accept.
- Assert iFLUSH after 7 samples, concurrently with the 8th → sample 8 is not written; idx=0; next sample goes to bank 0 addr 0; no oSTART.
- Deassert iRESET during RUN_WAIT_HIGH → all outputs take reset values asynchronously, oREADY=1 after release; a full new frame loads correctly.
